tsmp_frame_buf: RTL and testbench

Store-and-forward frame buffer placed directly downstream of the TSMP dispatcher, on the HCP or PLC branch (one instance per branch). It accepts the dispatcher's 9-bit byte stream, which has no backpressure, and writes each frame into an internal RAM. A frame is released to the consumer only after its tail byte has arrived and its length has been checked. Frames that are runt, oversize or overflowing are discarded without leaving any residue in the buffer.

---
 rtl/tsmp_frame_buf.sv | 205 ++++++++++++++++++++
 tb/tb_tsmp_frame_buf.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsmp_frame_buf.sv
// rtl/tsmp_frame_buf.sv - store-and-forward frame buffer behind the TSMP dispatcher
//
// Accepts a 9-bit byte stream with no backpressure and writes each frame into an
// internal RAM. A frame becomes visible to the reader only once its tail has
// arrived and its length is within [MIN_LEN, MAX_LEN]. Runt, oversize and
// overflowing frames are rolled back so that they leave nothing in the RAM.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   iv_data, i_data_wr   input byte and its valid (MSB = frame boundary flag)
//   ov_data, o_data_wr   output byte and its valid (MSB on first/last byte)
//   i_data_ready         consumer ready; a byte moves on o_data_wr && i_data_ready
//   ov_frame_cnt         committed frames not yet fully read
//   o_drop               one-cycle pulse per discarded frame
//   ov_rx_frame_cnt,     saturating statistics counters, present only when
//   ov_drop_cnt          TSMP_FRAME_BUF_STAT_EN is defined
module tsmp_frame_buf #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 9,
    parameter int MIN_LEN    = 14,
    parameter int MAX_LEN    = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_wr,
    input  logic                  i_data_ready,
    output logic [ADDR_WIDTH:0]   ov_frame_cnt,
    output logic                  o_drop
`ifdef TSMP_FRAME_BUF_STAT_EN
    ,
    output logic [15:0]           ov_rx_frame_cnt,
    output logic [15:0]           ov_drop_cnt
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] MIN_L = PW'(MIN_LEN);
    localparam logic [PW-1:0] MAX_L = PW'(MAX_LEN);
    localparam logic [PW-1:0] ONE   = PW'(1);

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_SEND} r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    w_state_t      w_state, w_state_nxt;
    r_state_t      r_state, r_state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt, rd_ptr;
    logic [PW-1:0] len, len_nxt, fill, len_inc, cnt_nxt;
    logic          mem_we, commit, drop_nxt, space, flag;
    logic          rd_load, tail_xfer, rd_in_frame, out_is_tail;
    logic [DATA_WIDTH-1:0] rd_byte;

    // Fill level uses rd_ptr before this cycle's read, so it may overstate by one.
    assign fill    = wr_ptr - rd_ptr;
    assign space   = ~fill[PW-1];
    assign flag    = iv_data[DATA_WIDTH-1];
    assign len_inc = len + ONE;

    // ---------------- write side ----------------
    always_comb begin
        w_state_nxt   = w_state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        len_nxt       = len;
        mem_we        = 1'b0;
        commit        = 1'b0;
        drop_nxt      = 1'b0;
        if (i_data_wr) begin
            case (w_state)
                W_IDLE: begin
                    if (flag) begin
                        if (space) begin
                            mem_we      = 1'b1;
                            wr_ptr_nxt  = wr_ptr + ONE;
                            len_nxt     = ONE;
                            w_state_nxt = W_RECV;
                        end else begin
                            drop_nxt    = 1'b1;
                            w_state_nxt = W_DROP;
                        end
                    end
                end
                W_RECV: begin
                    if (!flag) begin
                        if (space && (len < MAX_L)) begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + ONE;
                            len_nxt    = len_inc;
                        end else begin
                            wr_ptr_nxt  = wr_commit;
                            len_nxt     = '0;
                            drop_nxt    = 1'b1;
                            w_state_nxt = W_DROP;
                        end
                    end else begin
                        if (space && (len_inc >= MIN_L) && (len_inc <= MAX_L)) begin
                            mem_we        = 1'b1;
                            wr_ptr_nxt    = wr_ptr + ONE;
                            wr_commit_nxt = wr_ptr + ONE;
                            commit        = 1'b1;
                        end else begin
                            wr_ptr_nxt = wr_commit;
                            drop_nxt   = 1'b1;
                        end
                        len_nxt     = '0;
                        w_state_nxt = W_IDLE;
                    end
                end
                W_DROP: begin
                    if (flag) w_state_nxt = W_IDLE;
                end
                default: w_state_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state   <= W_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            len       <= '0;
            o_drop    <= 1'b0;
        end else begin
            w_state   <= w_state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            len       <= len_nxt;
            o_drop    <= drop_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= iv_data;
    end

    // ---------------- read side ----------------
    // ov_data/o_data_wr form the output stage; it is refilled from the RAM in the
    // same cycle its byte is taken, giving one byte per cycle with ready held high.
    // Only committed bytes (rd_ptr != wr_commit) are ever fetched.
    assign rd_byte   = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_load   = (r_state == R_SEND) && (rd_ptr != wr_commit) &&
                       (!o_data_wr || i_data_ready);
    assign tail_xfer = o_data_wr && i_data_ready && out_is_tail;

    always_comb begin
        cnt_nxt     = ov_frame_cnt;
        r_state_nxt = r_state;
        case ({commit, tail_xfer})
            2'b10:   cnt_nxt = ov_frame_cnt + ONE;
            2'b01:   cnt_nxt = ov_frame_cnt - ONE;
            default: cnt_nxt = ov_frame_cnt;
        endcase
        case (r_state)
            R_IDLE:  if (ov_frame_cnt != '0) r_state_nxt = R_SEND;
            R_SEND:  if (tail_xfer && (cnt_nxt == '0)) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= R_IDLE;
            rd_ptr       <= '0;
            ov_data      <= '0;
            o_data_wr    <= 1'b0;
            out_is_tail  <= 1'b0;
            rd_in_frame  <= 1'b0;
            ov_frame_cnt <= '0;
        end else begin
            r_state      <= r_state_nxt;
            ov_frame_cnt <= cnt_nxt;
            if (rd_load) begin
                ov_data     <= rd_byte;
                o_data_wr   <= 1'b1;
                rd_ptr      <= rd_ptr + ONE;
                // Both head and tail carry the flag; parity of flagged bytes tells them apart.
                out_is_tail <= rd_byte[DATA_WIDTH-1] && rd_in_frame;
                if (rd_byte[DATA_WIDTH-1]) rd_in_frame <= ~rd_in_frame;
            end else if (i_data_ready) begin
                o_data_wr   <= 1'b0;
                out_is_tail <= 1'b0;
            end
        end
    end

`ifdef TSMP_FRAME_BUF_STAT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_rx_frame_cnt <= '0;
            ov_drop_cnt     <= '0;
        end else begin
            if (commit && (ov_rx_frame_cnt != 16'hFFFF))
                ov_rx_frame_cnt <= ov_rx_frame_cnt + 16'd1;
            if (drop_nxt && (ov_drop_cnt != 16'hFFFF))
                ov_drop_cnt <= ov_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tsmp_frame_buf.sv
// tb/tb_tsmp_frame_buf.sv - self-checking bench for tsmp_frame_buf
module tb_tsmp_frame_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] iv_data;
    logic       i_data_wr;
    logic [8:0] ov_data;
    logic       o_data_wr;
    logic       i_data_ready;
    logic [9:0] ov_frame_cnt;
    logic       o_drop;

    int n_checks  = 0;
    int n_fail    = 0;
    int drop_seen = 0;
    logic [8:0] sb [$];
    logic [8:0] exp_b;

    always #5 clk = ~clk;

    tsmp_frame_buf #(
        .DATA_WIDTH(9),
        .ADDR_WIDTH(9),
        .MIN_LEN(14),
        .MAX_LEN(256)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .iv_data(iv_data),
        .i_data_wr(i_data_wr),
        .ov_data(ov_data),
        .o_data_wr(o_data_wr),
        .i_data_ready(i_data_ready),
        .ov_frame_cnt(ov_frame_cnt),
        .o_drop(o_drop)
    );

    // Scoreboard: every transferred byte must be the next expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_drop) drop_seen++;
            if (o_data_wr && i_data_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, required no output byte", ov_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (ov_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h, required %h", ov_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] gen_byte(input int i, input int len);
        logic [7:0] r;
        r = 8'($urandom);
        return {(i == 0) || (i == len - 1), r};
    endfunction

    // Leaves the tail driven; the caller's next cycle deasserts i_data_wr.
    task automatic send_frame(input int len, input bit keep, input bit gaps);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = gen_byte(i, len);
            @(posedge clk); #1;
            iv_data = b;
            i_data_wr = 1'b1;
            if (keep) sb.push_back(b);
            if (gaps && (i != len - 1) && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk); #1;
                i_data_wr = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_data_wr = 1'b0;
        end
    endtask

    task automatic wait_empty(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0) && (c < budget)) begin
            @(posedge clk); #1;
            i_data_wr = 1'b0;
            c++;
        end
        idle(3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; iv_data = '0; i_data_wr = 1'b0; i_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ov_data !== 9'h0)      begin n_fail++; $display("FAIL rst_data: got %h, required 0", ov_data); end
        n_checks++; if (o_data_wr !== 1'b0)    begin n_fail++; $display("FAIL rst_wr: got %b, required 0", o_data_wr); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d, required 0", ov_frame_cnt); end
        n_checks++; if (o_drop !== 1'b0)       begin n_fail++; $display("FAIL rst_drop: got %b, required 0", o_drop); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        int run;
        i_data_ready = 1'b1;
        send_frame(20, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL basic_cnt_pre: got %0d, required 0", ov_frame_cnt); end
        @(posedge clk); #1;
        i_data_wr = 1'b0;
        n_checks++; if (ov_frame_cnt !== 10'd1) begin n_fail++; $display("FAIL basic_cnt_commit: got %0d, required 1", ov_frame_cnt); end
        n_checks++; if (o_data_wr !== 1'b0) begin n_fail++; $display("FAIL basic_wr_e0: got %b, required 0", o_data_wr); end
        @(posedge clk); #1;
        n_checks++; if (o_data_wr !== 1'b0) begin n_fail++; $display("FAIL basic_wr_e1: got %b, required 0", o_data_wr); end
        @(posedge clk); #1;
        n_checks++; if (o_data_wr !== 1'b1) begin n_fail++; $display("FAIL basic_wr_e2: got %b, required 1", o_data_wr); end
        run = 0;
        while ((o_data_wr === 1'b1) && (run < 40)) begin
            run++;
            @(posedge clk); #1;
        end
        n_checks++; if (run != 20) begin n_fail++; $display("FAIL basic_run: got %0d cycles, required 20", run); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_sb: got %0d left, required 0", sb.size()); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL basic_cnt_end: got %0d, required 0", ov_frame_cnt); end
    endtask

    task automatic test_runt;
        int d0, seen;
        i_data_ready = 1'b1;
        d0 = drop_seen;
        send_frame(10, 1'b0, 1'b0);
        @(posedge clk); #1;
        i_data_wr = 1'b0;
        n_checks++; if (o_drop !== 1'b1) begin n_fail++; $display("FAIL runt_drop_hi: got %b, required 1", o_drop); end
        @(posedge clk); #1;
        n_checks++; if (o_drop !== 1'b0) begin n_fail++; $display("FAIL runt_drop_lo: got %b, required 0", o_drop); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (o_data_wr) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL runt_out: got %0d valid cycles, required 0", seen); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL runt_cnt: got %0d, required 0", ov_frame_cnt); end
        n_checks++; if (drop_seen - d0 != 1) begin n_fail++; $display("FAIL runt_npulse: got %0d, required 1", drop_seen - d0); end
        send_frame(14, 1'b1, 1'b1);
        idle(1);
        wait_empty(100);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL runt_next_sb: got %0d left, required 0", sb.size()); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL runt_next_cnt: got %0d, required 0", ov_frame_cnt); end
    endtask

    task automatic test_oversize;
        int d0;
        i_data_ready = 1'b1;
        d0 = drop_seen;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            iv_data = gen_byte(i, 300);
            i_data_wr = 1'b1;
            if (i == 257) begin
                n_checks++; if (o_drop !== 1'b1) begin n_fail++; $display("FAIL over_drop_257: got %b, required 1", o_drop); end
            end
        end
        idle(4);
        n_checks++; if (drop_seen - d0 != 1) begin n_fail++; $display("FAIL over_npulse: got %0d, required 1", drop_seen - d0); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL over_cnt: got %0d, required 0", ov_frame_cnt); end
        send_frame(20, 1'b1, 1'b1);
        idle(1);
        wait_empty(100);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL over_next_sb: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_fill;
        int d0, cnt, c;
        int msb_pos [$];
        i_data_ready = 1'b0;
        d0 = drop_seen;
        send_frame(200, 1'b1, 1'b0);
        send_frame(200, 1'b1, 1'b0);
        send_frame(200, 1'b0, 1'b0);
        idle(3);
        n_checks++; if (drop_seen - d0 != 1) begin n_fail++; $display("FAIL fill_npulse: got %0d, required 1", drop_seen - d0); end
        n_checks++; if (ov_frame_cnt !== 10'd2) begin n_fail++; $display("FAIL fill_cnt: got %0d, required 2", ov_frame_cnt); end
        i_data_ready = 1'b1;
        cnt = 0; c = 0;
        while ((cnt < 400) && (c < 1000)) begin
            @(negedge clk);
            if (o_data_wr && i_data_ready) begin
                cnt++;
                if (ov_data[8]) msb_pos.push_back(cnt);
            end
            c++;
        end
        idle(5);
        n_checks++; if (cnt != 400) begin n_fail++; $display("FAIL fill_bytes: got %0d, required 400", cnt); end
        n_checks++;
        if ((msb_pos.size() != 4) || (msb_pos[0] != 1) || (msb_pos[1] != 200) ||
            (msb_pos[2] != 201) || (msb_pos[3] != 400)) begin
            n_fail++;
            $display("FAIL fill_msb: got %0d flagged bytes, required 4 at 1,200,201,400", msb_pos.size());
        end
        n_checks++; if (o_data_wr !== 1'b0) begin n_fail++; $display("FAIL fill_extra: got %b, required 0", o_data_wr); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL fill_cnt_end: got %0d, required 0", ov_frame_cnt); end
    endtask

    task automatic test_toggle;
        logic [8:0] held;
        bit pending;
        i_data_ready = 1'b0;
        pending = 1'b0;
        held = '0;
        send_frame(20, 1'b1, 1'b1);
        idle(5);
        for (int c = 0; (c < 200) && (sb.size() != 0); c++) begin
            @(posedge clk); #1;
            i_data_ready = ~i_data_ready;
            @(negedge clk);
            if (pending) begin
                n_checks++;
                if ((o_data_wr !== 1'b1) || (ov_data !== held)) begin
                    n_fail++;
                    $display("FAIL toggle_hold: got %b/%h, required 1/%h", o_data_wr, ov_data, held);
                end
                pending = 1'b0;
            end
            if (!i_data_ready && o_data_wr) begin
                held = ov_data;
                pending = 1'b1;
            end
        end
        i_data_ready = 1'b1;
        idle(3);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL toggle_sb: got %0d left, required 0", sb.size()); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL toggle_cnt: got %0d, required 0", ov_frame_cnt); end
    endtask

    task automatic test_back_to_back;
        int d0;
        i_data_ready = 1'b1;
        d0 = drop_seen;
        send_frame(16, 1'b1, 1'b0);
        send_frame(16, 1'b1, 1'b0);
        idle(1);
        wait_empty(200);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb: got %0d left, required 0", sb.size()); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL b2b_cnt: got %0d, required 0", ov_frame_cnt); end
        n_checks++; if (drop_seen != d0) begin n_fail++; $display("FAIL b2b_drop: got %0d, required 0", drop_seen - d0); end
    endtask

    task automatic test_reset_mid;
        i_data_ready = 1'b0;
        send_frame(20, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (ov_frame_cnt !== 10'd1) begin n_fail++; $display("FAIL rmid_cnt_pre: got %0d, required 1", ov_frame_cnt); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            iv_data = gen_byte(i, 100);
            i_data_wr = 1'b1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_data_wr !== 1'b0) begin n_fail++; $display("FAIL rmid_wr: got %b, required 0", o_data_wr); end
        n_checks++; if (ov_data !== 9'h0) begin n_fail++; $display("FAIL rmid_data: got %h, required 0", ov_data); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d, required 0", ov_frame_cnt); end
        n_checks++; if (o_drop !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got %b, required 0", o_drop); end
        i_data_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_data_ready = 1'b1;
        send_frame(20, 1'b1, 1'b1);
        idle(1);
        wait_empty(100);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rmid_next_sb: got %0d left, required 0", sb.size()); end
        n_checks++; if (ov_frame_cnt !== 10'd0) begin n_fail++; $display("FAIL rmid_next_cnt: got %0d, required 0", ov_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_runt();
        test_oversize();
        test_fill();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
